// File: rtl/cicero_job_loader.sv
// Job sequencer in front of AXI_top: writes code/string words, sets the pointers, starts the run, polls status and returns one result per job.
// Optional WAIT watchdog: define CICERO_JOB_LOADER_TIMEOUT_EN.
module cicero_job_loader #(
  parameter int REG_WIDTH      = 32,
  parameter int MEM_BYTES      = 4096,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [15:0]          job_code_words,
  input  logic [15:0]          job_string_bytes,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_WIDTH-1:0] in_data,
  output logic [REG_WIDTH-1:0] address_register,
  output logic [REG_WIDTH-1:0] data_in_register,
  output logic [REG_WIDTH-1:0] start_cc_pointer_register,
  output logic [REG_WIDTH-1:0] end_cc_pointer_register,
  output logic [REG_WIDTH-1:0] cmd_register,
  input  logic [REG_WIDTH-1:0] status_register,
  input  logic [REG_WIDTH-1:0] data_o_register,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_accepted,
  output logic                 res_error,
  output logic                 res_timeout,
  output logic [REG_WIDTH-1:0] res_cycles
);

  localparam logic [REG_WIDTH-1:0] CMD_NOP                = REG_WIDTH'(0);
  localparam logic [REG_WIDTH-1:0] CMD_WRITE              = REG_WIDTH'(1);
  localparam logic [REG_WIDTH-1:0] CMD_START              = REG_WIDTH'(2);
  localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = REG_WIDTH'(5);
  localparam logic [REG_WIDTH-1:0] STATUS_RUNNING         = REG_WIDTH'(1);
  localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED        = REG_WIDTH'(2);
  localparam logic [REG_WIDTH-1:0] STATUS_REJECTED        = REG_WIDTH'(3);
  localparam logic [17:0]          MEM_WORDS              = 18'(MEM_BYTES / 4);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PTR, S_START, S_WAIT, S_RDCC, S_RDCAP, S_RESULT
  } state_t;

  state_t               state_q, state_d;
  logic                 job_ready_q, job_ready_d;
  logic                 in_ready_q, in_ready_d;
  logic [REG_WIDTH-1:0] addr_q, addr_d;
  logic [REG_WIDTH-1:0] wdata_q, wdata_d;
  logic [REG_WIDTH-1:0] sptr_q, sptr_d;
  logic [REG_WIDTH-1:0] eptr_q, eptr_d;
  logic [REG_WIDTH-1:0] cmd_q, cmd_d;
  logic                 res_valid_q, res_valid_d;
  logic                 res_acc_q, res_acc_d;
  logic                 res_err_q, res_err_d;
  logic [REG_WIDTH-1:0] res_cyc_q, res_cyc_d;
  logic [15:0]          cw_q, cw_d;
  logic [15:0]          sb_q, sb_d;
  logic [17:0]          total_q, total_d;
  logic [17:0]          k_q, k_d;
  logic [1:0]           st_cnt_q, st_cnt_d;
  logic [17:0]          req_sw, req_total, ss, se;

`ifdef CICERO_JOB_LOADER_TIMEOUT_EN
  logic [REG_WIDTH-1:0] wd_q, wd_d;
  logic                 res_to_q, res_to_d;
  assign res_timeout = res_to_q;
`else
  assign res_timeout = 1'b0;
`endif

  assign job_ready                 = job_ready_q;
  assign in_ready                  = in_ready_q;
  assign address_register          = addr_q;
  assign data_in_register          = wdata_q;
  assign start_cc_pointer_register = sptr_q;
  assign end_cc_pointer_register   = eptr_q;
  assign cmd_register              = cmd_q;
  assign res_valid                 = res_valid_q;
  assign res_accepted              = res_acc_q;
  assign res_error                 = res_err_q;
  assign res_cycles                = res_cyc_q;

  // Bounds check is done in words: 4*CW + 4*SW > MEM_BYTES  <=>  CW + SW > MEM_BYTES/4.
  always_comb begin
    req_sw    = ({2'b00, job_string_bytes} + 18'd3) >> 2;
    req_total = {2'b00, job_code_words} + req_sw;
    ss        = {cw_q, 2'b00};
    se        = ss + {2'b00, sb_q} - 18'd1;
  end

  always_comb begin
    state_d     = state_q;
    job_ready_d = job_ready_q;
    in_ready_d  = in_ready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sptr_d      = sptr_q;
    eptr_d      = eptr_q;
    cmd_d       = CMD_NOP;
    res_valid_d = res_valid_q;
    res_acc_d   = res_acc_q;
    res_err_d   = res_err_q;
    res_cyc_d   = res_cyc_q;
    cw_d        = cw_q;
    sb_d        = sb_q;
    total_d     = total_q;
    k_d         = k_q;
    st_cnt_d    = st_cnt_q;
`ifdef CICERO_JOB_LOADER_TIMEOUT_EN
    wd_d        = wd_q;
    res_to_d    = res_to_q;
`endif
    case (state_q)
      S_IDLE: begin
        job_ready_d = 1'b1;
        if (job_valid && job_ready_q) begin
          job_ready_d = 1'b0;
          cw_d        = job_code_words;
          sb_d        = job_string_bytes;
          total_d     = req_total;
          if (job_code_words == 16'd0 || job_string_bytes == 16'd0 || req_total > MEM_WORDS) begin
            res_err_d   = 1'b1;
            res_valid_d = 1'b1;
            state_d     = S_RESULT;
          end else begin
            in_ready_d = 1'b1;
            k_d        = 18'd0;
            state_d    = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          addr_d  = REG_WIDTH'(k_q);
          wdata_d = in_data;
          cmd_d   = CMD_WRITE;
          k_d     = k_q + 18'd1;
          if (k_q == total_q - 18'd1) begin
            in_ready_d = 1'b0;
            state_d    = S_PTR;
          end
        end
      end
      S_PTR: begin
        sptr_d   = REG_WIDTH'(ss);
        eptr_d   = REG_WIDTH'(se);
        st_cnt_d = 2'd0;
        state_d  = S_START;
      end
      // cycles 0 and 1 request START (visible one clock later); cycle 2 sees the response
      S_START: begin
        st_cnt_d = st_cnt_q + 2'd1;
        if (st_cnt_q != 2'd2) begin
          cmd_d = CMD_START;
        end else if (status_register !== STATUS_RUNNING) begin
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end else begin
`ifdef CICERO_JOB_LOADER_TIMEOUT_EN
          wd_d    = '0;
`endif
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
`ifdef CICERO_JOB_LOADER_TIMEOUT_EN
        wd_d = wd_q + REG_WIDTH'(1);
`endif
        if (status_register == STATUS_ACCEPTED) begin
          res_acc_d = 1'b1;
          cmd_d     = CMD_READ_ELAPSED_CLOCK;
          state_d   = S_RDCC;
        end else if (status_register == STATUS_REJECTED) begin
          res_acc_d = 1'b0;
          cmd_d     = CMD_READ_ELAPSED_CLOCK;
          state_d   = S_RDCC;
        end else if (status_register != STATUS_RUNNING) begin
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end
`ifdef CICERO_JOB_LOADER_TIMEOUT_EN
        else if (wd_q == REG_WIDTH'(TIMEOUT_CYCLES)) begin
          res_to_d    = 1'b1;
          res_acc_d   = 1'b0;
          res_cyc_d   = wd_q;
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end
`endif
      end
      S_RDCC: begin
        state_d = S_RDCAP;
      end
      S_RDCAP: begin
        res_cyc_d   = data_o_register;
        res_valid_d = 1'b1;
        state_d     = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          res_acc_d   = 1'b0;
          res_err_d   = 1'b0;
          res_cyc_d   = '0;
`ifdef CICERO_JOB_LOADER_TIMEOUT_EN
          res_to_d    = 1'b0;
`endif
          job_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      job_ready_q <= 1'b0;
      in_ready_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sptr_q      <= '0;
      eptr_q      <= '0;
      cmd_q       <= CMD_NOP;
      res_valid_q <= 1'b0;
      res_acc_q   <= 1'b0;
      res_err_q   <= 1'b0;
      res_cyc_q   <= '0;
      cw_q        <= '0;
      sb_q        <= '0;
      total_q     <= '0;
      k_q         <= '0;
      st_cnt_q    <= '0;
`ifdef CICERO_JOB_LOADER_TIMEOUT_EN
      wd_q        <= '0;
      res_to_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      job_ready_q <= job_ready_d;
      in_ready_q  <= in_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sptr_q      <= sptr_d;
      eptr_q      <= eptr_d;
      cmd_q       <= cmd_d;
      res_valid_q <= res_valid_d;
      res_acc_q   <= res_acc_d;
      res_err_q   <= res_err_d;
      res_cyc_q   <= res_cyc_d;
      cw_q        <= cw_d;
      sb_q        <= sb_d;
      total_q     <= total_d;
      k_q         <= k_d;
      st_cnt_q    <= st_cnt_d;
`ifdef CICERO_JOB_LOADER_TIMEOUT_EN
      wd_q        <= wd_d;
      res_to_q    <= res_to_d;
`endif
    end
  end

endmodule
